// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 encryptor definitions: round geometry and the round-controller state type.
package sm4_encryptor;

    localparam int rounds_p          = 32;
    localparam int round_idx_width_p = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } sm4_ctrl_state_e;

endpackage

// File: rtl/sm4_round_counter.sv
// Round index counter: cleared on request, stepped while a phase runs, flags the final round.
module sm4_round_counter
    import sm4_encryptor::*;
#(
    parameter int count_p = 32,
    parameter int width_p = $clog2(count_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               zero_i,
    input  logic               incr_i,
    output logic [width_p-1:0] count_o,
    output logic               last_o
);

    localparam logic [width_p-1:0] last_val_lp = width_p'(count_p - 1);

    // Stepping past the last round returns to zero instead of overflowing.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (zero_i || (incr_i && last_o)) begin
            count_o <= '0;
        end else if (incr_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

    assign last_o = (count_o == last_val_lp);

endmodule

// File: rtl/sm4_round_ctrl.sv
// SM4 round controller: sequences key expansion into the round-key RAM and data rounds out of it.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; result leaves when data_v_o & data_yumi_i.
module sm4_round_ctrl
    import sm4_encryptor::*;
#(
    parameter int rounds_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        key_v_i,
    output logic                        key_ready_o,
    input  logic                        data_v_i,
    output logic                        data_ready_o,
    input  logic                        decrypt_i,
    output logic                        data_v_o,
    input  logic                        data_yumi_i,
    output logic                        key_loaded_o,
    output logic                        dp_load_o,
    output logic                        dp_mode_o,
    output logic                        dp_en_o,
    output logic [$clog2(rounds_p)-1:0] dp_round_o,
    output logic                        rk_we_o,
    output logic [$clog2(rounds_p)-1:0] rk_waddr_o,
    output logic [$clog2(rounds_p)-1:0] rk_raddr_o,
    output logic                        busy_o,
    output sm4_ctrl_state_e             state_o
);

    localparam int                  idx_w_lp    = $clog2(rounds_p);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(rounds_p - 1);

    sm4_ctrl_state_e     state_q, state_n;
    logic [idx_w_lp-1:0] round;
    logic                last_round;
    logic                key_loaded_q;
    logic                decrypt_q;
    logic                key_xfer;
    logic                data_xfer;
    logic                round_incr;

    // A pending key request masks data acceptance in the same cycle.
    assign key_xfer   = (state_q == IDLE) && key_v_i && !reset_i;
    assign data_xfer  = (state_q == IDLE) && data_v_i && key_loaded_q && !key_v_i && !reset_i;
    assign round_incr = (state_q == KEXP) || (state_q == DATA);

    sm4_round_counter #(
        .count_p (rounds_p),
        .width_p (idx_w_lp)
    ) u_round_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .zero_i  (key_xfer | data_xfer),
        .incr_i  (round_incr),
        .count_o (round),
        .last_o  (last_round)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // The key set only counts as loaded once the final expansion round is written.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            key_loaded_q <= 1'b0;
            decrypt_q    <= 1'b0;
        end else begin
            if (key_xfer) begin
                key_loaded_q <= 1'b0;
            end else if ((state_q == KEXP) && last_round) begin
                key_loaded_q <= 1'b1;
            end
            if (data_xfer) begin
                decrypt_q <= decrypt_i;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (key_xfer) begin
                    state_n = KEXP;
                end else if (data_xfer) begin
                    state_n = DATA;
                end
            end
            KEXP:    if (last_round)  state_n = IDLE;
            DATA:    if (last_round)  state_n = DONE;
            DONE:    if (data_yumi_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Reset forces every handshake and strobe low, regardless of state.
    always_comb begin
        key_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        data_v_o     = 1'b0;
        dp_load_o    = 1'b0;
        dp_mode_o    = 1'b0;
        dp_en_o      = 1'b0;
        dp_round_o   = '0;
        rk_we_o      = 1'b0;
        rk_waddr_o   = '0;
        rk_raddr_o   = '0;
        busy_o       = 1'b0;
        key_loaded_o = key_loaded_q;
        state_o      = state_q;
        if (!reset_i) begin
            case (state_q)
                IDLE: begin
                    key_ready_o  = 1'b1;
                    data_ready_o = key_loaded_q & ~key_v_i;
                    dp_load_o    = key_xfer | data_xfer;
                    dp_mode_o    = data_xfer;
                end
                KEXP: begin
                    busy_o     = 1'b1;
                    dp_en_o    = 1'b1;
                    dp_round_o = round;
                    rk_we_o    = 1'b1;
                    rk_waddr_o = round;
                end
                DATA: begin
                    busy_o     = 1'b1;
                    dp_en_o    = 1'b1;
                    dp_mode_o  = 1'b1;
                    dp_round_o = round;
                    rk_raddr_o = decrypt_q ? (last_idx_lp - round) : round;
                end
                DONE: begin
                    busy_o   = 1'b1;
                    data_v_o = 1'b1;
                end
                default: begin
                    busy_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Self-checking bench for sm4_round_ctrl: transaction-level countdown model plus directed literal checks.
module tb_sm4_round_ctrl;

    localparam int ROUNDS = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_v = 1'b0;
    logic       data_v = 1'b0;
    logic       decrypt = 1'b0;
    logic       yumi = 1'b0;
    logic       key_ready, data_ready, data_v_o, key_loaded;
    logic       dp_load, dp_mode, dp_en, rk_we, busy;
    logic [4:0] dp_round, rk_waddr, rk_raddr;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    sm4_round_ctrl #(.rounds_p(ROUNDS)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .key_v_i      (key_v),
        .key_ready_o  (key_ready),
        .data_v_i     (data_v),
        .data_ready_o (data_ready),
        .decrypt_i    (decrypt),
        .data_v_o     (data_v_o),
        .data_yumi_i  (yumi),
        .key_loaded_o (key_loaded),
        .dp_load_o    (dp_load),
        .dp_mode_o    (dp_mode),
        .dp_en_o      (dp_en),
        .dp_round_o   (dp_round),
        .rk_we_o      (rk_we),
        .rk_waddr_o   (rk_waddr),
        .rk_raddr_o   (rk_raddr),
        .busy_o       (busy),
        .state_o      (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Model: counts down remaining rounds of the current job, then holds the result.
    logic m_loaded = 1'b0;
    logic m_dec    = 1'b0;
    logic m_done   = 1'b0;
    logic m_kind   = 1'b0;
    int   m_left   = 0;

    always @(negedge clk) begin : monitor
        int e_kr, e_dr, e_dv, e_kl, e_ld, e_md, e_en, e_rd, e_we, e_wa, e_ra, e_bz, r;
        e_kr = 0; e_dr = 0; e_dv = 0; e_ld = 0; e_md = 0; e_en = 0;
        e_rd = 0; e_we = 0; e_wa = 0; e_ra = 0; e_bz = 0; r = 0;
        e_kl = int'(m_loaded);
        if (rst) begin
            e_kl = 0;
        end else if (m_left > 0) begin
            r    = ROUNDS - m_left;
            e_en = 1;
            e_bz = 1;
            e_rd = r;
            e_md = int'(m_kind);
            if (!m_kind) begin
                e_we = 1;
                e_wa = r;
            end else begin
                e_ra = m_dec ? (ROUNDS - 1 - r) : r;
            end
        end else if (m_done) begin
            e_dv = 1;
            e_bz = 1;
        end else begin
            e_kr = 1;
            e_dr = int'(m_loaded && !key_v);
            if (key_v) begin
                e_ld = 1;
            end else if (data_v && m_loaded) begin
                e_ld = 1;
                e_md = 1;
            end
        end
        chk("m_key_ready",  int'(key_ready),  e_kr);
        chk("m_data_ready", int'(data_ready), e_dr);
        chk("m_data_v",     int'(data_v_o),   e_dv);
        chk("m_key_loaded", int'(key_loaded), e_kl);
        chk("m_dp_load",    int'(dp_load),    e_ld);
        chk("m_dp_mode",    int'(dp_mode),    e_md);
        chk("m_dp_en",      int'(dp_en),      e_en);
        chk("m_dp_round",   int'(dp_round),   e_rd);
        chk("m_rk_we",      int'(rk_we),      e_we);
        chk("m_rk_waddr",   int'(rk_waddr),   e_wa);
        chk("m_rk_raddr",   int'(rk_raddr),   e_ra);
        chk("m_busy",       int'(busy),       e_bz);
        if (rst) begin
            m_loaded <= 1'b0;
            m_dec    <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                if (!m_kind) m_loaded <= 1'b1;
                else         m_done   <= 1'b1;
            end
        end else if (m_done) begin
            if (yumi) m_done <= 1'b0;
        end else if (key_v) begin
            m_left   <= ROUNDS;
            m_kind   <= 1'b0;
            m_loaded <= 1'b0;
        end else if (data_v && m_loaded) begin
            m_left <= ROUNDS;
            m_kind <= 1'b1;
            m_dec  <= decrypt;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key();
        tick(); key_v = 1'b1;
        @(negedge clk);
        chk("kx_load", int'(dp_load), 1);
        chk("kx_mode", int'(dp_mode), 0);
        for (int i = 0; i < ROUNDS; i++) begin
            tick(); key_v = 1'b0;
            @(negedge clk);
            chk("kexp_we",    int'(rk_we),    1);
            chk("kexp_waddr", int'(rk_waddr), i);
            chk("kexp_round", int'(dp_round), i);
        end
        tick();
        @(negedge clk);
        chk("kexp_loaded", int'(key_loaded), 1);
        chk("kexp_idle",   int'(busy),       0);
    endtask

    task automatic run_block(input logic dec, input int hold);
        tick(); data_v = 1'b1; decrypt = dec;
        @(negedge clk);
        chk("dx_load",  int'(dp_load),    1);
        chk("dx_mode",  int'(dp_mode),    1);
        chk("dx_ready", int'(data_ready), 1);
        for (int i = 0; i < ROUNDS; i++) begin
            tick(); data_v = 1'b0; decrypt = ~dec; yumi = (i % 3 == 0);
            @(negedge clk);
            chk("data_raddr", int'(rk_raddr), dec ? (ROUNDS - 1 - i) : i);
            chk("data_en",    int'(dp_en),    1);
            chk("data_nov",   int'(data_v_o), 0);
        end
        tick(); yumi = 1'b0;
        @(negedge clk);
        chk("done_v", int'(data_v_o), 1);
        for (int k = 0; k < hold; k++) begin
            tick();
            @(negedge clk);
            chk("hold_v",     int'(data_v_o),   1);
            chk("hold_kr",    int'(key_ready),  0);
            chk("hold_dr",    int'(data_ready), 0);
        end
        tick(); yumi = 1'b1;
        @(negedge clk);
        chk("yumi_v", int'(data_v_o), 1);
        tick(); yumi = 1'b0;
        @(negedge clk);
        chk("after_v",    int'(data_v_o),  0);
        chk("after_busy", int'(busy),      0);
        chk("after_kr",   int'(key_ready), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_kr",     int'(key_ready),  0);
        chk("rst_loaded", int'(key_loaded), 0);
        tick(); rst = 1'b0; data_v = 1'b1;
        @(negedge clk);
        chk("post_rst_kr",   int'(key_ready),  1);
        chk("post_rst_dr",   int'(data_ready), 0);
        chk("post_rst_load", int'(dp_load),    0);
        tick(); data_v = 1'b0;

        load_key();
        run_block(1'b0, 0);
        run_block(1'b1, 5);

        // Key and data requested together with a key already loaded
        tick(); key_v = 1'b1; data_v = 1'b1; decrypt = 1'b0;
        @(negedge clk);
        chk("coll_dr",   int'(data_ready), 0);
        chk("coll_load", int'(dp_load),    1);
        chk("coll_mode", int'(dp_mode),    0);
        for (int i = 0; i < ROUNDS; i++) begin
            tick(); key_v = 1'b0;
            @(negedge clk);
            chk("coll_stall", int'(data_ready), 0);
        end
        tick();
        @(negedge clk);
        chk("coll_dr2",  int'(data_ready), 1);
        chk("coll_mode2", int'(dp_mode),   1);
        for (int i = 0; i < ROUNDS; i++) begin
            tick(); data_v = 1'b0;
            @(negedge clk);
            chk("coll_raddr", int'(rk_raddr), i);
        end
        tick();
        @(negedge clk);
        chk("coll_done", int'(data_v_o), 1);
        tick(); yumi = 1'b1;
        @(negedge clk);
        tick(); yumi = 1'b0;
        @(negedge clk);

        // Reset in the middle of key expansion
        tick(); key_v = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            tick(); key_v = 1'b0;
            @(negedge clk);
        end
        chk("mid_waddr", int'(rk_waddr), 10);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_we",     int'(rk_we),      0);
        chk("mid_rst_en",     int'(dp_en),      0);
        chk("mid_rst_busy",   int'(busy),       0);
        chk("mid_rst_loaded", int'(key_loaded), 0);
        chk("mid_rst_kr",     int'(key_ready),  0);
        chk("mid_rst_dr",     int'(data_ready), 0);
        tick();
        @(negedge clk);
        tick(); rst = 1'b0; data_v = 1'b1;
        @(negedge clk);
        chk("mid_after_dr",     int'(data_ready), 0);
        chk("mid_after_loaded", int'(key_loaded), 0);
        chk("mid_after_load",   int'(dp_load),    0);
        tick(); data_v = 1'b0;

        load_key();
        run_block(1'b1, 1);

        tick();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
